// File: rtl/lut_bank_cfg_pkg.sv
// Shared types and sizing helpers for the reprogrammable LUT bank.
package lut_bank_cfg_pkg;

    // Configuration loader states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    // Number of configuration words needed to cover a 2**n-bit table.
    function automatic int calc_words(input int n, input int w);
        return ((1 << n) + w - 1) / w;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

endpackage

// File: rtl/lut_cell.sv
// Single N-input lookup table: loadable table register plus registered read.
module lut_cell #(
    parameter int                N    = 2,
    parameter logic [2**N-1:0]   INIT = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [2**N-1:0]      wdata,
    input  logic [N-1:0]         idx,
    output logic                 q
);

    logic [2**N-1:0] table_reg;
    logic            q_reg;

    // Table contents: reset to INIT, replaced wholesale on a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_reg <= INIT;
        end else if (we) begin
            table_reg <= wdata;
        end
    end

    // Registered lookup; a same-edge write is not yet visible here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= table_reg[idx];
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/lut_bank_cfg.sv
// Bank of C lookup tables rewritten through a word-serial valid/ready port.
// Words collect in a shadow register and are committed to one channel at once.
module lut_bank_cfg
    import lut_bank_cfg_pkg::*;
#(
    parameter int              N    = 2,
    parameter int              C    = 4,
    parameter int              W    = 8,
    parameter logic [2**N-1:0] INIT = 4'h5,
    localparam int             K    = calc_words(N, W),
    localparam int             CHW  = ch_width(C)
) (
    input  logic               CLK,
    input  logic               ASYNCRESET,
    input  logic [C*N-1:0]     I,
    input  logic               I_VALID,
    output logic [C-1:0]       O,
    output logic               O_VALID,
    input  logic               CFG_VALID,
    output logic               CFG_READY,
    input  logic [CHW-1:0]     CFG_CH,
    input  logic [W-1:0]       CFG_DATA,
    input  logic               CFG_LAST,
    output logic               CFG_ERR
);

    localparam int D    = 2**N;
    localparam int SW   = K * W;
    localparam int CNTW = $clog2(K + 1);

    cfg_state_t      state_reg, state_next;
    logic [SW-1:0]   shadow_reg, shadow_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic [CHW-1:0]  ch_reg, ch_next;
    logic            err_reg, err_next;
    logic            o_valid_reg;
    logic            hs;
    logic            word_is_last;
    logic [CHW-1:0]  ch_sel;
    logic            ch_in_range;
    logic            commit;

    assign CFG_READY    = (state_reg != COMMIT);
    assign hs           = CFG_VALID & CFG_READY;
    assign commit       = (state_reg == COMMIT);
    // The first word carries the channel; later words use the latched one.
    assign ch_sel       = (state_reg == IDLE) ? CFG_CH : ch_reg;
    assign ch_in_range  = (int'(ch_sel) < C);
    assign word_is_last = (state_reg == IDLE) ? (K == 1) : (cnt_reg == CNTW'(K - 1));

    // Loader next-state: collect words, validate framing, schedule commit.
    always_comb begin
        state_next  = state_reg;
        shadow_next = shadow_reg;
        cnt_next    = cnt_reg;
        ch_next     = ch_reg;
        err_next    = 1'b0;
        case (state_reg)
            IDLE, LOAD: begin
                if (hs) begin
                    if (CFG_LAST != word_is_last) begin
                        // Framing error: drop the partial load.
                        err_next    = 1'b1;
                        shadow_next = '0;
                        cnt_next    = '0;
                        state_next  = IDLE;
                    end else begin
                        if (state_reg == IDLE) begin
                            ch_next     = CFG_CH;
                            shadow_next = '0;
                        end
                        for (int k = 0; k < K; k++) begin
                            if (cnt_reg == CNTW'(k)) begin
                                shadow_next[k*W +: W] = CFG_DATA;
                            end
                        end
                        cnt_next = cnt_reg + CNTW'(1);
                        if (word_is_last) begin
                            // An out-of-range channel matches no cell, so the
                            // commit cycle writes nothing and only flags it.
                            state_next = COMMIT;
                            err_next   = ~ch_in_range;
                        end else begin
                            state_next = LOAD;
                        end
                    end
                end
            end
            COMMIT: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Loader state registers.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_reg  <= IDLE;
            shadow_reg <= '0;
            cnt_reg    <= '0;
            ch_reg     <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shadow_reg <= shadow_next;
            cnt_reg    <= cnt_next;
            ch_reg     <= ch_next;
            err_reg    <= err_next;
        end
    end

    // Lookup qualifier follows the registered lookup by one cycle.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            o_valid_reg <= 1'b0;
        end else begin
            o_valid_reg <= I_VALID;
        end
    end

    assign O_VALID = o_valid_reg;
    assign CFG_ERR = err_reg;

    // Bits of the last word past the table depth are never used.
    generate
        if (SW > D) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^shadow_reg[SW-1:D];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < C; gi++) begin : g_cell
            lut_cell #(
                .N    (N),
                .INIT (INIT)
            ) u_cell (
                .clk   (CLK),
                .rst   (ASYNCRESET),
                .we    (commit && (ch_reg == CHW'(gi))),
                .wdata (shadow_reg[D-1:0]),
                .idx   (I[gi*N +: N]),
                .q     (O[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_lut_bank_cfg.sv
// Bench for lut_bank_cfg: a K=1 bank (N=2,C=4) and a K=2 bank (N=4,C=3).
module tb_lut_bank_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Bank A: N=2, C=4, W=8, INIT=4'h5 (K=1)
    logic       rst_a, iv_a, ov_a, cv_a, rdy_a, last_a, err_a;
    logic [7:0] i_a, data_a;
    logic [3:0] o_a;
    logic [1:0] ch_a;

    // Bank B: N=4, C=3, W=8, INIT=16'hA5C3 (K=2)
    logic        rst_b, iv_b, ov_b, cv_b, rdy_b, last_b, err_b;
    logic [11:0] i_b;
    logic [7:0]  data_b;
    logic [2:0]  o_b;
    logic [1:0]  ch_b;

    localparam logic [15:0] INIT_B = 16'hA5C3;

    int n_vec = 0;
    int n_err = 0;

    lut_bank_cfg #(.N(2), .C(4), .W(8), .INIT(4'h5)) dut_a (
        .CLK(clk), .ASYNCRESET(rst_a), .I(i_a), .I_VALID(iv_a), .O(o_a), .O_VALID(ov_a),
        .CFG_VALID(cv_a), .CFG_READY(rdy_a), .CFG_CH(ch_a), .CFG_DATA(data_a),
        .CFG_LAST(last_a), .CFG_ERR(err_a)
    );

    lut_bank_cfg #(.N(4), .C(3), .W(8), .INIT(INIT_B)) dut_b (
        .CLK(clk), .ASYNCRESET(rst_b), .I(i_b), .I_VALID(iv_b), .O(o_b), .O_VALID(ov_b),
        .CFG_VALID(cv_b), .CFG_READY(rdy_b), .CFG_CH(ch_b), .CFG_DATA(data_b),
        .CFG_LAST(last_b), .CFG_ERR(err_b)
    );

    typedef struct {
        logic [7:0] i;
        logic       iv;
        logic [3:0] o;
        logic       ov;
        logic       after_load;
    } vec_t;

    vec_t vecs [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One handshake word on bank B (ready is high in IDLE/LOAD).
    task automatic b_word(input logic [1:0] ch, input logic [7:0] data, input logic last);
        cv_b = 1'b1; ch_b = ch; data_b = data; last_b = last;
        tick;
        cv_b = 1'b0; last_b = 1'b0;
    endtask

    // Sweep every index on all bank-B channels against expected tables.
    task automatic check_tbl_b(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2);
        logic [3:0] x;
        for (int idx = 0; idx < 16; idx++) begin
            x = 4'(idx);
            i_b = {x, x, x}; iv_b = 1'b1;
            tick;
            chk("b_sweep", {o_b, ov_b}, {t2[idx], t1[idx], t0[idx], 1'b1});
        end
    endtask

    task automatic load_a;
        chk("a_ready_idle", 32'(rdy_a), 32'd1);
        cv_a = 1'b1; ch_a = 2'd2; data_a = 8'h0A; last_a = 1'b1;
        tick;
        cv_a = 1'b0; last_a = 1'b0;
        chk("a_commit_cycle", {rdy_a, err_a}, 2'b00);
        tick;
        chk("a_back_idle", {rdy_a, err_a}, 2'b10);
    endtask

    // Reference model state for the randomized phase on bank B.
    logic [15:0] mt [3];
    logic [7:0]  mw [2];
    int          mch, words;
    bit          commit_now;

    initial begin
        logic        loaded;
        logic        r_iv, r_cv, r_last;
        logic [11:0] r_i;
        logic [1:0]  r_ch;
        logic [7:0]  r_data;
        logic [2:0]  exp_o;

        i_a = '0; iv_a = 0; cv_a = 0; ch_a = '0; data_a = '0; last_a = 0;
        i_b = '0; iv_b = 0; cv_b = 0; ch_b = '0; data_b = '0; last_b = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        tick; tick;
        chk("a_reset", {o_a, ov_a, rdy_a, err_a}, {4'b0000, 1'b0, 1'b1, 1'b0});
        chk("b_reset", {o_b, ov_b, rdy_b, err_b}, {3'b000, 1'b0, 1'b1, 1'b0});
        rst_a = 1'b0; rst_b = 1'b0;

        // Bank A table-driven lookups around a one-word load of channel 2.
        vecs[0] = '{8'b11_10_01_00, 1'b1, 4'b0101, 1'b1, 1'b0};
        vecs[1] = '{8'b00_00_00_00, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[2] = '{8'b11_11_11_11, 1'b1, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{8'b10_01_11_10, 1'b1, 4'b1001, 1'b1, 1'b0};
        vecs[4] = '{8'b00_01_00_00, 1'b1, 4'b1111, 1'b1, 1'b1};
        vecs[5] = '{8'b00_00_00_00, 1'b1, 4'b1011, 1'b1, 1'b1};
        vecs[6] = '{8'b11_11_11_11, 1'b0, 4'b0100, 1'b0, 1'b1};
        vecs[7] = '{8'b01_10_01_11, 1'b1, 4'b0000, 1'b1, 1'b1};
        loaded = 1'b0;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].after_load && !loaded) begin
                load_a();
                loaded = 1'b1;
            end
            i_a = vecs[v].i; iv_a = vecs[v].iv;
            tick;
            chk("a_lut", {o_a, ov_a}, {vecs[v].o, vecs[v].ov});
        end

        // Bank B: two-word load of channel 1; COMMIT-cycle lookup sees old table.
        b_word(2'd1, 8'h34, 1'b0);
        chk("b_load_ready", {rdy_b, err_b}, 2'b10);
        b_word(2'd1, 8'h12, 1'b1);
        chk("b_commit_cycle", {rdy_b, err_b}, 2'b00);
        i_b = 12'h000; iv_b = 1'b1;
        tick;
        chk("b_commit_lookup_old", {o_b, rdy_b}, {3'b111, 1'b1});
        check_tbl_b(INIT_B, 16'h1234, INIT_B);

        // LAST on word 0 of a two-word load.
        b_word(2'd0, 8'hFF, 1'b1);
        chk("b_early_last_err", {rdy_b, err_b}, 2'b11);
        tick;
        chk("b_err_pulse_end", 32'(err_b), 32'd0);
        // LAST missing on the final word.
        b_word(2'd0, 8'hFF, 1'b0);
        chk("b_word0_no_err", 32'(err_b), 32'd0);
        b_word(2'd0, 8'hFF, 1'b0);
        chk("b_missing_last_err", {rdy_b, err_b}, 2'b11);
        tick;
        chk("b_err_pulse_end2", 32'(err_b), 32'd0);
        check_tbl_b(INIT_B, 16'h1234, INIT_B);

        // Channel index beyond C-1.
        b_word(2'd3, 8'hFF, 1'b0);
        b_word(2'd3, 8'hEE, 1'b1);
        chk("b_bad_ch_err", {rdy_b, err_b}, 2'b01);
        tick;
        chk("b_bad_ch_after", {rdy_b, err_b}, 2'b10);
        check_tbl_b(INIT_B, 16'h1234, INIT_B);

        // Asynchronous reset in the middle of a load.
        i_b = 12'h000; iv_b = 1'b1;
        tick;
        chk("b_pre_reset_o", {o_b, ov_b}, {3'b101, 1'b1});
        b_word(2'd0, 8'h77, 1'b0);
        #2;
        rst_b = 1'b1;
        #1;
        chk("b_async_reset", {o_b, ov_b, rdy_b, err_b}, {3'b000, 1'b0, 1'b1, 1'b0});
        tick;
        rst_b = 1'b0;
        b_word(2'd0, 8'hAA, 1'b0);
        b_word(2'd0, 8'h55, 1'b1);
        tick;
        check_tbl_b(16'h55AA, INIT_B, INIT_B);

        // Randomized traffic on bank B against a protocol-level model.
        mt[0] = 16'h55AA; mt[1] = INIT_B; mt[2] = INIT_B;
        words = 0; mch = 0; commit_now = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r_iv   = 1'($urandom_range(0, 1));
            r_i    = 12'($urandom);
            r_cv   = 1'($urandom_range(0, 1));
            r_ch   = 2'($urandom_range(0, 2));
            r_data = 8'($urandom);
            r_last = (words == 1);
            for (int c = 0; c < 3; c++) begin
                exp_o[c] = mt[c][r_i[c*4 +: 4]];
            end
            i_b = r_i; iv_b = r_iv; cv_b = r_cv; ch_b = r_ch; data_b = r_data; last_b = r_last;
            tick;
            if (commit_now) begin
                mt[mch] = {mw[1], mw[0]};
                commit_now = 1'b0;
            end else if (r_cv) begin
                if (words == 0) mch = int'(r_ch);
                mw[words] = r_data;
                words++;
                if (words == 2) begin
                    commit_now = 1'b1;
                    words = 0;
                end
            end
            chk("b_random", {o_b, ov_b, rdy_b, err_b}, {exp_o, r_iv, ~commit_now, 1'b0});
        end
        cv_b = 1'b0; last_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut_bank_cfg.md
# lut_bank_cfg

Runtime-reprogrammable bank of C independent N-input lookup tables with registered outputs. Successor to the fixed-init single LUT primitive: each table resets to a parameter value but can be rewritten through a word-serial configuration port with a valid/ready handshake and atomic per-channel commit. Sits between datapath logic needing small configurable boolean functions and the control/config fabric.

## Interface
- N, 2, inputs per LUT (table depth 2**N bits), 1..6
- C, 4, number of LUT channels, 1..16
- W, 8, configuration word width, 1..32
- INIT, 4'h5, reset table (2**N bits) loaded into every channel
- K (derived localparam), ceil(2**N / W), config words per channel
- CLK  in  1  clock, all state on rising edge
- ASYNCRESET  in  1  asynchronous, active-high reset
- I  in  C*N  lookup indices; channel c uses I[c*N +: N]
- I_VALID  in  1  lookup request qualifier
- O  out  C  registered lookup results; O[c] = table[c][index c]
- O_VALID  out  1  I_VALID delayed one cycle
- CFG_VALID  in  1  config word valid
- CFG_READY  out  1  config word accepted when VALID&READY
- CFG_CH  in  max(1,clog2(C))  target channel, sampled on first word only
- CFG_DATA  in  W  config word, least-significant word first
- CFG_LAST  in  1  marks final word of a channel load
- CFG_ERR  out  1  one-cycle pulse: load aborted

## Operation
- Lookup: every cycle, O <= {table[c][I[c*N +: N]]}; O_VALID <= I_VALID. O updates regardless of I_VALID.
- Config FSM, states IDLE, LOAD, COMMIT:
  - IDLE: CFG_READY=1. On handshake latch CFG_CH, write word 0 into shadow, cnt=1; go COMMIT if K==1 else LOAD.
  - LOAD: CFG_READY=1. Each handshake writes shadow[cnt*W +: W], cnt++; on cnt reaching K go COMMIT.
  - COMMIT: CFG_READY=0. Copy shadow to table[ch]; return to IDLE next cycle.
- CFG_LAST must be 1 on word K and 0 on all earlier words. Violation: pulse CFG_ERR, discard shadow, return to IDLE; table unchanged.
- CFG_CH >= C (only reachable when C not a power of two): detected at commit, CFG_ERR pulse, no write.
- Bits of the final word beyond 2**N are ignored.
- No handshake cycle: FSM holds, partial load persists indefinitely.

## Timing
- Reset: all tables = INIT, O = 0, O_VALID = 0, CFG_READY = 1 (IDLE), CFG_ERR = 0, cnt = 0, shadow = 0.
- Lookup latency 1 cycle; full throughput.
- Table write occurs at the COMMIT clock edge; lookup sampled in the COMMIT cycle uses the old table, the following cycle sees the new one.
- Channel load occupies K handshake cycles + 1 COMMIT cycle; minimum back-to-back load period K+1.
- CFG_ERR asserted the cycle after the offending handshake.
- ASYNCRESET mid-load: shadow discarded, every channel returns to INIT immediately, O forced to 0.

## Structure
- Shared package: state enum (IDLE/LOAD/COMMIT), K computation function, channel-index width function.
- One sub-module natural: lut_cell (single N-input table register with write-enable, parallel load and registered read), instantiated C times; top holds the config FSM, shadow and counter.

## Test plan
- Reset, N=2, C=4, INIT=4'h5: I=8'b11_10_01_00, I_VALID=1 -> next cycle O=4'b0101, O_VALID=1.
- Load ch 2 with 8'h0A (K=1, CFG_LAST=1) -> one COMMIT cycle with CFG_READY=0; then index 1 on ch 2 gives 1, index 0 gives 0; other channels still 4'h5.
- N=4, W=8 (K=2): load ch 1 words 8'h34, 8'h12 -> table 16'h1234; sweep indices 0..15 matches; lookup in COMMIT cycle still returns INIT.
- CFG_LAST on word 0 with K=2 -> CFG_ERR pulse, table unchanged; missing CFG_LAST on word 1 -> same.
- C=3: load to CFG_CH=3 -> CFG_ERR, no channel modified.
- Assert ASYNCRESET after first of two words -> O=0, CFG_READY=1 immediately; subsequent full load succeeds normally.
